ray_point_eval: RTL
===================

Name: ray_point_eval

Overview:
- Pipelined stage that evaluates ray points P = O + t*D for the intersection datapath.
- Consumes a ray origin O, a direction D and a parameter t. Produces the 57-bit point vector {x, y, z} in the same sign-magnitude fixed-point format.
- Stage 1 scales D by t. Stage 2 adds O.
- Valid/ready handshake on both sides. A tag travels with each transaction.

Parameters:
- INT_BITS, 8, integer magnitude bits per component.
- FRAC_BITS, 10, fraction bits per component.
- TAG_WIDTH, 8, width of the pass-through transaction tag.
- Derived, not overridable: CW = 1+INT_BITS+FRAC_BITS (19); VW = 3*CW (57).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  stage can accept input this cycle.
- in_t  in  CW  ray parameter t, sign-magnitude.
- in_dir  in  VW  direction {x,y,z}; x in [56:38], y in [37:19], z in [18:0].
- in_origin  in  VW  origin {x,y,z}, same packing.
- in_tag  in  TAG_WIDTH  opaque ray index.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_point  out  VW  P = O + t*D, packed {x,y,z}.
- out_tag  out  TAG_WIDTH  tag of the result.
- out_sat  out  1  some component saturated in either stage.

Behaviour:
- Component format: bit CW-1 is the sign (1 = negative), then INT_BITS integer bits, then FRAC_BITS fraction bits. Magnitude max is 18'h3FFFF (255.999).
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_point=0, out_tag=0, out_sat=0. Data registers clear to 0. Reset mid-operation discards all in-flight transactions. No output appears after reset release until new input arrives.
- Handshake:
  - s2_en = !s2_valid | out_ready.
  - s1_en = !s1_valid | s2_en.
  - in_ready = s1_en, a combinational path from out_ready.
  - A transfer occurs when valid & ready are both 1 on a rising edge.
  - out_point, out_tag and out_sat hold stable while out_valid=1 and out_ready=0.
- Latency: 2 cycles from input acceptance to out_valid with no stall. Throughput is 1 per cycle. Ordering is strictly preserved. No transaction is dropped or duplicated.
- Stage 1 (registered when s1_en):
  - Per component, prod = t_mag * d_mag, a full 2*(CW-1)-bit product.
  - mag = prod[FRAC_BITS+CW-2 : FRAC_BITS], i.e. [27:10] by default, truncated with no rounding.
  - If any bit of prod above that field is 1, mag = all-ones and sat1 = 1.
  - sign = t_sign ^ d_sign.
  - Origin and tag are registered alongside.
- Stage 2 (registered when s2_en), per component, a sign-magnitude saturating add of O and the stage-1 product:
  - Same signs: mag = a+b. On carry-out, mag = all-ones and sat2 = 1. Sign is kept.
  - Different signs: mag = |larger| - |smaller|, with the sign of the larger magnitude.
  - Equal magnitudes with opposite signs give +0.
- Zero normalisation: any zero magnitude (from stage 1 or stage 2) is emitted with sign 0. Negative zero never leaves the block.
- out_sat = OR of the sat flags from all three components across both stages, for that transaction.
- Simultaneous events:
  - Accepting input while the output drains in the same cycle is legal at full rate.
  - in_valid while in_ready=0 has no effect; upstream must hold its data.

Decomposition:
- Shared package ray_fx_pkg:
  - INT_BITS/FRAC_BITS/CW/VW constants.
  - SAT_MAG constant (all-ones magnitude).
  - Component get/put functions for {x,y,z} slicing.
  - Sign-magnitude multiply function, reused by the existing scaler stage.
- One sub-module sm_add_sat: combinational sign-magnitude saturating adder with a sat output, instantiated 3x in stage 2.

Test Plan:
- Basic evaluation, no stall:
  - Stimulus: t=19'h00800 (2.0), D=(19'h00400, 19'h40200, 19'h00100), O=(19'h00400, 19'h00400, 19'h40400), tag=8'h05.
  - Response: two cycles later, out_point={19'h00C00, 19'h00000, 19'h40200}, out_tag=8'h05, out_sat=0.
- Multiply saturation:
  - Stimulus: t=19'h32000 (200.0), D.x=19'h00800, O.x=0.
  - Response: out x=19'h3FFFF, out_sat=1. Components y/z with D=0 give 0.
- Add saturation and sign:
  - Stimulus: t=19'h00400, D.x=19'h32000, O.x=19'h19000.
  - Response: x=19'h3FFFF, out_sat=1.
  - With O.x=19'h59000 (-100.0), x=19'h19000, out_sat=0.
- Negative zero:
  - Stimulus: t=19'h40400 (-1.0), D=(0,0,0), O=(0,0,0).
  - Response: out_point=57'h0, all sign bits 0.
- Backpressure:
  - Stimulus: hold out_ready=0, present tags 1,2,3 back-to-back.
  - Response: in_ready drops after tags 1 and 2 are accepted, and outputs stay stable.
  - Releasing out_ready yields tags 1, 2, 3 in order on consecutive cycles with no loss.
- Reset mid-flight:
  - Stimulus: assert rst_n=0 asynchronously with 2 transactions in flight.
  - Response: out_valid=0 immediately, without waiting for a clock edge.
  - After release, no stale output appears and the next input produces its result after 2 cycles.

Source files
------------

// File: rtl/ray_fx_pkg.sv
// Shared fixed-point helpers for the ray datapath: sign-magnitude components
// (sign, INT_BITS integer bits, FRAC_BITS fraction bits) packed as {x,y,z}.
package ray_fx_pkg;

  localparam int INT_BITS  = 8;
  localparam int FRAC_BITS = 10;
  localparam int CW        = 1 + INT_BITS + FRAC_BITS;
  localparam int MW        = CW - 1;
  localparam int VW        = 3 * CW;

  localparam logic [MW-1:0] SAT_MAG = '1;

  typedef logic [CW-1:0] comp_t;
  typedef logic [VW-1:0] vec_t;

  typedef struct packed {
    logic  sat;
    comp_t c;
  } mul_res_t;

  // Component 0 is x (most significant slice), 2 is z.
  function automatic comp_t get_comp(input vec_t v, input int idx);
    return v[(2-idx)*CW +: CW];
  endfunction

  function automatic vec_t put_comp(input vec_t v, input int idx, input comp_t c);
    vec_t r;
    r = v;
    r[(2-idx)*CW +: CW] = c;
    return r;
  endfunction

  // Truncating sign-magnitude multiply; saturates when the product does not
  // fit the magnitude field and never returns a negative zero.
  function automatic mul_res_t sm_mul(input comp_t t, input comp_t d);
    logic [2*MW-1:0] prod;
    mul_res_t        r;
    prod = {{MW{1'b0}}, t[MW-1:0]} * {{MW{1'b0}}, d[MW-1:0]};
    r.sat = |prod[2*MW-1:FRAC_BITS+MW];
    r.c[MW-1:0] = r.sat ? SAT_MAG : prod[FRAC_BITS+MW-1:FRAC_BITS];
    r.c[MW] = (t[MW] ^ d[MW]) & (r.c[MW-1:0] != '0);
    return r;
  endfunction

endpackage

// File: rtl/sm_add_sat.sv
// Combinational sign-magnitude adder that clamps to the largest magnitude on
// overflow and always reports zero as +0.
module sm_add_sat #(
  parameter int CW = 19
) (
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  output logic [CW-1:0] sum_o,
  output logic          sat_o
);

  localparam int MW = CW - 1;

  logic [MW:0]   sum_w;
  logic [MW-1:0] mag;
  logic          sign;

  // Add or subtract magnitudes depending on the operand signs.
  always_comb begin
    sum_w = {1'b0, a_i[MW-1:0]} + {1'b0, b_i[MW-1:0]};
    mag   = '0;
    sign  = 1'b0;
    sat_o = 1'b0;
    if (a_i[MW] == b_i[MW]) begin
      sign = a_i[MW];
      if (sum_w[MW]) begin
        mag   = '1;
        sat_o = 1'b1;
      end else begin
        mag = sum_w[MW-1:0];
      end
    end else if (a_i[MW-1:0] >= b_i[MW-1:0]) begin
      mag  = a_i[MW-1:0] - b_i[MW-1:0];
      sign = a_i[MW];
    end else begin
      mag  = b_i[MW-1:0] - a_i[MW-1:0];
      sign = b_i[MW];
    end
    if (mag == '0) begin
      sign = 1'b0;
    end
    sum_o = {sign, mag};
  end

endmodule

// File: rtl/ray_point_eval.sv
// Two-stage ray point evaluator: stage 1 scales the direction by t, stage 2
// adds the origin. The tag and a saturation flag ride along with the data.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Each stage advances when it is empty or the stage after it is
// advancing, so in_ready is a combinational function of out_ready and the
// stage occupancy. Output fields hold while out_valid=1 and out_ready=0.
module ray_point_eval #(
  parameter int INT_BITS  = 8,
  parameter int FRAC_BITS = 10,
  parameter int TAG_WIDTH = 8,
  localparam int CW = 1 + INT_BITS + FRAC_BITS,
  localparam int VW = 3 * CW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CW-1:0]        in_t,
  input  logic [VW-1:0]        in_dir,
  input  logic [VW-1:0]        in_origin,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [VW-1:0]        out_point,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_sat
);

  logic                 s1_valid_q;
  logic [VW-1:0]        s1_prod_q;
  logic [VW-1:0]        s1_origin_q;
  logic [TAG_WIDTH-1:0] s1_tag_q;
  logic                 s1_sat_q;

  logic                 out_valid_q;
  logic [VW-1:0]        out_point_q;
  logic [TAG_WIDTH-1:0] out_tag_q;
  logic                 out_sat_q;

  logic s1_en, s2_en;

  logic [VW-1:0]          s1_prod_d;
  logic                   s1_sat_d;
  ray_fx_pkg::mul_res_t   mul_r;

  logic [VW-1:0] out_point_d;
  logic [2:0]    sat2_w;
  logic          out_sat_d;

  assign s2_en    = !out_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;

  // Stage 1 datapath: per-component t * D with saturation.
  always_comb begin
    s1_prod_d = '0;
    s1_sat_d  = 1'b0;
    mul_r     = '0;
    for (int i = 0; i < 3; i++) begin
      mul_r     = ray_fx_pkg::sm_mul(in_t, ray_fx_pkg::get_comp(in_dir, i));
      s1_prod_d = ray_fx_pkg::put_comp(s1_prod_d, i, mul_r.c);
      s1_sat_d  = s1_sat_d | mul_r.sat;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_add
    sm_add_sat #(.CW(CW)) u_add (
      .a_i   (s1_origin_q[g*CW +: CW]),
      .b_i   (s1_prod_q[g*CW +: CW]),
      .sum_o (out_point_d[g*CW +: CW]),
      .sat_o (sat2_w[g])
    );
  end

  assign out_sat_d = s1_sat_q | (|sat2_w);

  // Stage 1 registers: capture the scaled direction, origin and tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_prod_q   <= '0;
      s1_origin_q <= '0;
      s1_tag_q    <= '0;
      s1_sat_q    <= 1'b0;
    end else if (s1_en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_prod_q   <= s1_prod_d;
        s1_origin_q <= in_origin;
        s1_tag_q    <= in_tag;
        s1_sat_q    <= s1_sat_d;
      end
    end
  end

  // Output registers: capture the final point once stage 1 hands it over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_point_q <= '0;
      out_tag_q   <= '0;
      out_sat_q   <= 1'b0;
    end else if (s2_en) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_point_q <= out_point_d;
        out_tag_q   <= s1_tag_q;
        out_sat_q   <= out_sat_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_point = out_point_q;
  assign out_tag   = out_tag_q;
  assign out_sat   = out_sat_q;

endmodule
